// File: rtl/proc_pkg.sv
// Shared definitions for the 10-bit processor: opcodes, ALU function codes,
// timestep encoding, instruction-word field positions and small decode helpers.
package proc_pkg;

  typedef enum logic [3:0] {
    OP_LOAD = 4'b0000,
    OP_MOV  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_NOT  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_XOR  = 4'b0111
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_NOT = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } timestep_e;

  localparam int IR_RX_MSB       = 9;
  localparam int IR_RX_LSB       = 8;
  localparam int IR_RY_MSB       = 7;
  localparam int IR_RY_LSB       = 6;
  localparam int IR_OP_MSB       = 3;
  localparam int IR_OP_LSB       = 0;
  localparam int OP_RESERVED_BIT = 3;

  function automatic logic [3:0] dec2to4(input logic [1:0] sel);
    logic [3:0] res;
    case (sel)
      2'd0:    res = 4'b0001;
      2'd1:    res = 4'b0010;
      2'd2:    res = 4'b0100;
      2'd3:    res = 4'b1000;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    logic [2:0] res;
    case (op)
      OP_ADD:  res = ALU_ADD;
      OP_SUB:  res = ALU_SUB;
      OP_NOT:  res = ALU_NOT;
      OP_AND:  res = ALU_AND;
      OP_OR:   res = ALU_OR;
      OP_XOR:  res = ALU_XOR;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/control_unit_checker.sv
// Run-time invariants on the control_unit enables: single bus driver,
// one-hot register selects, idle ALU code when G is not being loaded.
module control_unit_checker (
  input logic       clk,
  input logic       rst_n,
  input logic       extout,
  input logic       gout,
  input logic [3:0] rout,
  input logic [3:0] rin,
  input logic       gin,
  input logic [2:0] aluop
);

  // Invariants sampled mid-cycle, once combinational decodes have settled.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (($countones(rout) + {31'd0, extout} + {31'd0, gout}) <= 32'd1)
        else $error("bus exclusivity violated");
      assert ($countones(rin) <= 32'd1)
        else $error("RIN not one-hot");
      assert (gin || (aluop == 3'b000))
        else $error("ALUOP nonzero while GIN low");
    end else begin
      assert ((rout == 4'b0000) && (rin == 4'b0000) && !extout && !gout && !gin)
        else $error("enables active in reset");
    end
  end

endmodule

// File: rtl/pulse_gen.sv
// EXECUTE rising-edge detector: one-cycle pulse per press, no pulse for a
// button already held high when reset is released.
module pulse_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic exec_q_r;
  logic armed_r;

  // Delayed copy of the button; arming requires the level to have been seen low once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_q_r <= 1'b0;
      armed_r  <= 1'b0;
    end else begin
      exec_q_r <= level;
      if (!level) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign pulse = level & ~exec_q_r & armed_r;

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: latches IR from DIN, steps TIME through T0..T3 and
// decodes the register/ALU/bus enables for the shared 10-bit BUS.
module control_unit
  import proc_pkg::*;
(
  input  logic       CLK,
  input  logic       CLRb,
  input  logic       EXECUTE,
  input  logic [9:0] DIN,
  output logic [9:0] IR,
  output logic [1:0] TIME,
  output logic       DONE,
  output logic       EXTOUT,
  output logic [3:0] ROUT,
  output logic [3:0] RIN,
  output logic       AIN,
  output logic       GIN,
  output logic       GOUT,
  output logic [2:0] ALUOP
);

  timestep_e  time_r;
  timestep_e  time_nxt_s;
  logic [9:0] ir_r;
  logic [9:0] ir_nxt_s;
  logic       pulse_s;
  logic [1:0] rx_s;
  logic [1:0] ry_s;
  logic [3:0] op_s;
  logic       reserved_s;
  logic       is_alu_s;

  pulse_gen u_pulse_gen (
    .clk   (CLK),
    .rst_n (CLRb),
    .level (EXECUTE),
    .pulse (pulse_s)
  );

  assign rx_s       = ir_r[IR_RX_MSB:IR_RX_LSB];
  assign ry_s       = ir_r[IR_RY_MSB:IR_RY_LSB];
  assign op_s       = ir_r[IR_OP_MSB:IR_OP_LSB];
  assign reserved_s = op_s[OP_RESERVED_BIT];
  assign is_alu_s   = ~reserved_s & (op_s != OP_LOAD) & (op_s != OP_MOV);

  // State register: timestep and instruction register.
  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      time_r <= T0;
      ir_r   <= 10'h000;
    end else begin
      time_r <= time_nxt_s;
      ir_r   <= ir_nxt_s;
    end
  end

  // Next-state logic; pulses outside T0 and the LOAD wait are dropped.
  always_comb begin
    time_nxt_s = time_r;
    ir_nxt_s   = ir_r;
    case (time_r)
      T0: begin
        if (pulse_s) begin
          ir_nxt_s   = DIN;
          time_nxt_s = T1;
        end else begin
          time_nxt_s = T0;
        end
      end
      T1: begin
        if (reserved_s || (op_s == OP_MOV)) begin
          time_nxt_s = T0;
        end else if (op_s == OP_LOAD) begin
          time_nxt_s = pulse_s ? T0 : T1;
        end else begin
          time_nxt_s = T2;
        end
      end
      T2:      time_nxt_s = T3;
      T3:      time_nxt_s = T0;
      default: time_nxt_s = T0;
    endcase
  end

  // Output decode; at most one bus driver is enabled in any timestep.
  always_comb begin
    DONE   = 1'b0;
    EXTOUT = 1'b0;
    ROUT   = 4'b0000;
    RIN    = 4'b0000;
    AIN    = 1'b0;
    GIN    = 1'b0;
    GOUT   = 1'b0;
    ALUOP  = 3'b000;
    case (time_r)
      T1: begin
        if (reserved_s) begin
          DONE = 1'b1;
        end else begin
          case (op_s)
            OP_LOAD: begin
              if (pulse_s) begin
                EXTOUT = 1'b1;
                RIN    = dec2to4(rx_s);
                DONE   = 1'b1;
              end else begin
                EXTOUT = 1'b0;
              end
            end
            OP_MOV: begin
              ROUT = dec2to4(ry_s);
              RIN  = dec2to4(rx_s);
              DONE = 1'b1;
            end
            default: begin
              ROUT = dec2to4(rx_s);
              AIN  = 1'b1;
            end
          endcase
        end
      end
      T2: begin
        if (is_alu_s) begin
          GIN   = 1'b1;
          ALUOP = alu_code(op_s);
          ROUT  = (op_s == OP_NOT) ? 4'b0000 : dec2to4(ry_s);
        end else begin
          GIN = 1'b0;
        end
      end
      T3: begin
        if (is_alu_s) begin
          GOUT = 1'b1;
          RIN  = dec2to4(rx_s);
          DONE = 1'b1;
        end else begin
          GOUT = 1'b0;
        end
      end
      default: begin
        DONE = 1'b0;
      end
    endcase
  end

  assign IR   = ir_r;
  assign TIME = time_r;

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit plus hand-written sequences for
// held EXECUTE and reset in the middle of an ALU instruction.
module tb_control_unit;

  logic       CLK;
  logic       CLRb;
  logic       EXECUTE;
  logic [9:0] DIN;
  logic [9:0] IR;
  logic [1:0] TIME;
  logic       DONE;
  logic       EXTOUT;
  logic [3:0] ROUT;
  logic [3:0] RIN;
  logic       AIN;
  logic       GIN;
  logic       GOUT;
  logic [2:0] ALUOP;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .CLK     (CLK),
    .CLRb    (CLRb),
    .EXECUTE (EXECUTE),
    .DIN     (DIN),
    .IR      (IR),
    .TIME    (TIME),
    .DONE    (DONE),
    .EXTOUT  (EXTOUT),
    .ROUT    (ROUT),
    .RIN     (RIN),
    .AIN     (AIN),
    .GIN     (GIN),
    .GOUT    (GOUT),
    .ALUOP   (ALUOP)
  );

  control_unit_checker u_chk (
    .clk    (CLK),
    .rst_n  (CLRb),
    .extout (EXTOUT),
    .gout   (GOUT),
    .rout   (ROUT),
    .rin    (RIN),
    .gin    (GIN),
    .aluop  (ALUOP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Packed view: {TIME, IR, DONE, EXTOUT, ROUT, RIN, AIN, GIN, GOUT, ALUOP}
  logic [27:0] act;
  assign act = {TIME, IR, DONE, EXTOUT, ROUT, RIN, AIN, GIN, GOUT, ALUOP};

  function automatic logic [27:0] mk(input logic [1:0] t, input logic [9:0] ir,
                                     input logic done, input logic ext,
                                     input logic [3:0] rout, input logic [3:0] rin,
                                     input logic ain, input logic gin,
                                     input logic gout, input logic [2:0] aluop);
    return {t, ir, done, ext, rout, rin, ain, gin, gout, aluop};
  endfunction

  task automatic check(input string name, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (TIME,IR,DONE,EXT,ROUT,RIN,AIN,GIN,GOUT,ALUOP)",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic        exec;
    logic [9:0]  din;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs[22];

  initial begin
    // MOV R2,R1
    vecs[0]  = '{1'b1, 10'h241, mk(2'd0, 10'h000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000)};
    vecs[1]  = '{1'b0, 10'h000, mk(2'd1, 10'h241, 1'b1, 1'b0, 4'b0010, 4'b0100, 1'b0, 1'b0, 1'b0, 3'b000)};
    vecs[2]  = '{1'b0, 10'h000, mk(2'd0, 10'h241, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000)};
    // ADD R1,R2 with an ignored pulse in T2
    vecs[3]  = '{1'b1, 10'h1A2, mk(2'd0, 10'h241, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000)};
    vecs[4]  = '{1'b0, 10'h000, mk(2'd1, 10'h1A2, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 3'b000)};
    vecs[5]  = '{1'b1, 10'h000, mk(2'd2, 10'h1A2, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b000)};
    vecs[6]  = '{1'b0, 10'h000, mk(2'd3, 10'h1A2, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b1, 3'b000)};
    vecs[7]  = '{1'b0, 10'h000, mk(2'd0, 10'h1A2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000)};
    // LOAD R0 then immediate 0x155 on the second pulse
    vecs[8]  = '{1'b1, 10'h000, mk(2'd0, 10'h1A2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000)};
    vecs[9]  = '{1'b0, 10'h155, mk(2'd1, 10'h000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000)};
    vecs[10] = '{1'b1, 10'h155, mk(2'd1, 10'h000, 1'b1, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 3'b000)};
    vecs[11] = '{1'b0, 10'h000, mk(2'd0, 10'h000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000)};
    // NOT R0 with an ignored pulse in T3
    vecs[12] = '{1'b1, 10'h0C4, mk(2'd0, 10'h000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000)};
    vecs[13] = '{1'b0, 10'h000, mk(2'd1, 10'h0C4, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 3'b000)};
    vecs[14] = '{1'b0, 10'h000, mk(2'd2, 10'h0C4, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b010)};
    vecs[15] = '{1'b1, 10'h241, mk(2'd3, 10'h0C4, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b1, 3'b000)};
    vecs[16] = '{1'b0, 10'h000, mk(2'd0, 10'h0C4, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000)};
    // OR R2,R3
    vecs[17] = '{1'b1, 10'h2D6, mk(2'd0, 10'h0C4, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000)};
    vecs[18] = '{1'b0, 10'h000, mk(2'd1, 10'h2D6, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 3'b000)};
    vecs[19] = '{1'b0, 10'h000, mk(2'd2, 10'h2D6, 1'b0, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b100)};
    vecs[20] = '{1'b0, 10'h000, mk(2'd3, 10'h2D6, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1, 3'b000)};
    vecs[21] = '{1'b0, 10'h000, mk(2'd0, 10'h2D6, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000)};

    CLRb    = 1'b0;
    EXECUTE = 1'b0;
    DIN     = 10'h000;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", 28'h0);
    CLRb = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    for (int i = 0; i < 22; i++) begin
      EXECUTE = vecs[i].exec;
      DIN     = vecs[i].din;
      @(negedge CLK);
      check($sformatf("vec%0d", i), vecs[i].exp);
      @(posedge CLK);
      #1;
    end

    // Reserved opcode with EXECUTE held for ten cycles: one instruction only.
    EXECUTE = 1'b1;
    DIN     = 10'h008;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (c == 0)
        check("nop_held_c0", mk(2'd0, 10'h2D6, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000));
      else if (c == 1)
        check("nop_held_c1", mk(2'd1, 10'h008, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000));
      else
        check($sformatf("nop_held_c%0d", c), mk(2'd0, 10'h008, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000));
      @(posedge CLK);
      #1;
    end
    EXECUTE = 1'b0;
    @(posedge CLK);
    #1;

    // Reset in T2 of an ADD, released with EXECUTE held high.
    EXECUTE = 1'b1;
    DIN     = 10'h1A2;
    @(posedge CLK);
    #1;
    EXECUTE = 1'b0;
    @(posedge CLK);
    #1;
    check("add_t2_before_reset", mk(2'd2, 10'h1A2, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 3'b000));
    CLRb    = 1'b0;
    EXECUTE = 1'b1;
    #1;
    check("async_reset_mid_add", 28'h0);
    @(posedge CLK);
    #1;
    CLRb = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check($sformatf("held_after_reset_c%0d", c), 28'h0);
      @(posedge CLK);
      #1;
    end
    EXECUTE = 1'b0;
    DIN     = 10'h0C1;
    @(posedge CLK);
    #1;
    EXECUTE = 1'b1;
    @(negedge CLK);
    check("post_reset_pulse_t0", 28'h0);
    @(posedge CLK);
    #1;
    EXECUTE = 1'b0;
    @(negedge CLK);
    check("post_reset_mov", mk(2'd1, 10'h0C1, 1'b1, 1'b0, 4'b1000, 4'b0001, 1'b0, 1'b0, 1'b0, 3'b000));
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("post_reset_idle", mk(2'd0, 10'h0C1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 3'b000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
